// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
//   Shared types and constants for the stream_demux_n block.
//   - slot_state_e : per-channel holding slot state (EMPTY/FULL)
//   - DEF_*        : default parameter values
//   - cnt_sat_max  : all-ones value of a w-bit counter (saturation point)
package stream_demux_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_CNT_W  = 8;

  // Largest value a w-bit unsigned counter can hold (w <= 63).
  function automatic logic [63:0] cnt_sat_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot
//   One-entry holding register with EMPTY/FULL state for one output channel.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : write load_data into the slot (only when can_load=1)
//     load_data  : payload to store
//     out_ready  : consumer takes the held word this cycle
//     out_valid  : slot holds a word
//     out_data   : held word; changes only on a load
//     can_load   : slot can take a word this cycle (empty, or draining now)
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              can_load
);

  slot_state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (load) out_data <= load_data;
    end
  end

  always_comb begin
    state_nxt = state;
    // out_ready feeds can_load combinationally so a full slot can drain and
    // reload in one cycle without a bubble.
    can_load  = (state == SLOT_EMPTY) | out_ready;
    out_valid = (state == SLOT_FULL);
    case (state)
      SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (out_ready && !load) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n
//   Registered 1-to-NUM_CH demultiplexer with valid/ready handshakes,
//   one holding slot per channel, broadcast mode, and invalid-select drop
//   detection with a saturating drop counter.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     in_data    : input payload
//     in_sel     : destination channel index
//     in_bcast   : deliver to every channel (in_sel ignored)
//     in_valid   : input word present
//     in_ready   : word accepted this cycle (combinational)
//     out_data   : channel i payload at [i*DATA_W +: DATA_W]
//     out_valid  : per-channel slot full
//     out_ready  : per-channel consumer ready
//     drop_pulse : one-cycle pulse after a word was dropped (bad select)
//     drop_cnt   : saturating count of dropped words
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     drop_pulse,
  output logic [CNT_W-1:0]         drop_cnt
);

  if (NUM_CH > (1 << SEL_W)) begin : g_bad_sel_w
    $error("stream_demux_n: NUM_CH exceeds 2**SEL_W");
  end
  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("stream_demux_n: NUM_CH must be in 2..16");
  end

  localparam logic [SEL_W:0]   NUM_CH_S = (SEL_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_sat_max(CNT_W));

  logic [NUM_CH-1:0]             can_load;
  logic [NUM_CH-1:0]             sel_hot;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0][DATA_W-1:0] slot_data;
  logic                          sel_ok;
  logic                          accept;
  logic                          drop_now;

  // One-hot decode; out-of-range selects give an all-zero vector, so no
  // out-of-bounds indexing is needed for can_load.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NUM_CH; i++) sel_hot[i] = (in_sel == SEL_W'(i));
  end

  assign sel_ok = ({1'b0, in_sel} < NUM_CH_S);

  // Broadcast waits until every slot can take the word so all copies land
  // in the same cycle. Invalid selects are always sunk.
  always_comb begin
    if (in_bcast)    in_ready = &can_load;
    else if (sel_ok) in_ready = |(sel_hot & can_load);
    else             in_ready = 1'b1;
  end

  assign accept   = in_valid & in_ready;
  assign load     = {NUM_CH{accept}} & ({NUM_CH{in_bcast}} | sel_hot);
  assign drop_now = accept & ~in_bcast & ~sel_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (slot_data[i]),
      .can_load  (can_load[i])
    );
  end

  assign out_data = slot_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop_now;
      if (drop_now && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench: DUT a uses default parameters (4 channels); DUT b uses
// NUM_CH=3, CNT_W=2 to exercise invalid selects and counter saturation.
module tb_stream_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a : DATA_W=8, NUM_CH=4, SEL_W=2, CNT_W=8
  logic        rst_a, in_bcast_a, in_valid_a, in_ready_a, drop_pulse_a;
  logic [7:0]  in_data_a, drop_cnt_a;
  logic [1:0]  in_sel_a;
  logic [31:0] out_data_a;
  logic [3:0]  out_valid_a, out_ready_a;

  // DUT b : DATA_W=8, NUM_CH=3, SEL_W=2, CNT_W=2
  logic        rst_b, in_bcast_b, in_valid_b, in_ready_b, drop_pulse_b;
  logic [7:0]  in_data_b;
  logic [1:0]  in_sel_b, drop_cnt_b;
  logic [23:0] out_data_b;
  logic [2:0]  out_valid_b, out_ready_b;

  stream_demux_n u_dut_a (
    .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_sel(in_sel_a),
    .in_bcast(in_bcast_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .drop_pulse(drop_pulse_a), .drop_cnt(drop_cnt_a)
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_sel(in_sel_b),
    .in_bcast(in_bcast_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .drop_pulse(drop_pulse_b), .drop_cnt(drop_cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic [1:0] s, input logic b);
    in_data_a = d; in_sel_a = s; in_bcast_a = b; in_valid_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b1; in_bcast_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    in_sel_a = '0; out_ready_a = 4'hF;
    rst_b = 1'b1; in_bcast_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    in_sel_b = '0; out_ready_b = 3'h7;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("rst_valid", 32'(out_valid_a), 32'h0);
    chk("rst_data", out_data_a, 32'h0);
    chk("rst_dpulse", 32'(drop_pulse_a), 32'h0);
    chk("rst_dcnt", 32'(drop_cnt_a), 32'h0);
    chk("rst_ready", 32'(in_ready_a), 32'h1);

    // Unicast A5 -> ch2, all consumers ready
    send_a(8'hA5, 2'd2, 1'b0);
    #1 chk("uni_ready", 32'(in_ready_a), 32'h1);
    step(); in_valid_a = 1'b0;
    chk("uni_valid", 32'(out_valid_a), 32'h4);
    chk("uni_data", 32'(out_data_a[23:16]), 32'hA5);
    step();
    chk("uni_drain", 32'(out_valid_a), 32'h0);
    chk("uni_hold", 32'(out_data_a[23:16]), 32'hA5);

    // Backpressure on ch1
    out_ready_a = 4'b1101;
    send_a(8'h11, 2'd1, 1'b0);
    step();
    chk("bp_first_v", 32'(out_valid_a), 32'h2);
    chk("bp_first_d", 32'(out_data_a[15:8]), 32'h11);
    send_a(8'h22, 2'd1, 1'b0);
    #1 chk("bp_stall_rdy", 32'(in_ready_a), 32'h0);
    step();
    chk("bp_keep_d", 32'(out_data_a[15:8]), 32'h11);
    chk("bp_keep_v", 32'(out_valid_a), 32'h2);
    out_ready_a = 4'hF;
    #1 chk("bp_rel_rdy", 32'(in_ready_a), 32'h1);
    step(); in_valid_a = 1'b0;
    chk("bp_second_v", 32'(out_valid_a), 32'h2);
    chk("bp_second_d", 32'(out_data_a[15:8]), 32'h22);
    step();
    chk("bp_empty", 32'(out_valid_a), 32'h0);

    // Same-cycle drain + load on ch0
    out_ready_a = 4'b1110;
    send_a(8'h33, 2'd0, 1'b0);
    step();
    chk("sc_first_d", 32'(out_data_a[7:0]), 32'h33);
    out_ready_a = 4'hF;
    send_a(8'h44, 2'd0, 1'b0);
    #1 chk("sc_ready", 32'(in_ready_a), 32'h1);
    step(); in_valid_a = 1'b0;
    chk("sc_valid", 32'(out_valid_a), 32'h1);
    chk("sc_data", 32'(out_data_a[7:0]), 32'h44);
    step();
    chk("sc_empty", 32'(out_valid_a), 32'h0);

    // Broadcast blocked by stalled ch3, then released
    out_ready_a = 4'b0111;
    send_a(8'h77, 2'd3, 1'b0);
    step();
    send_a(8'h5A, 2'd0, 1'b1);
    #1 chk("bc_block_rdy", 32'(in_ready_a), 32'h0);
    step();
    chk("bc_block_v", 32'(out_valid_a), 32'h8);
    chk("bc_block_d", 32'(out_data_a[31:24]), 32'h77);
    out_ready_a = 4'hF;
    #1 chk("bc_rel_rdy", 32'(in_ready_a), 32'h1);
    step(); in_valid_a = 1'b0; in_bcast_a = 1'b0;
    chk("bc_all_v", 32'(out_valid_a), 32'hF);
    chk("bc_all_d", out_data_a, 32'h5A5A5A5A);
    chk("bc_no_drop", 32'(drop_cnt_a), 32'h0);

    // Invalid select on the 3-channel instance
    in_data_b = 8'hEE; in_sel_b = 2'd3; in_valid_b = 1'b1;
    #1 chk("inv_ready", 32'(in_ready_b), 32'h1);
    step(); in_valid_b = 1'b0;
    chk("inv_valid", 32'(out_valid_b), 32'h0);
    chk("inv_pulse", 32'(drop_pulse_b), 32'h1);
    chk("inv_cnt", 32'(drop_cnt_b), 32'h1);
    step();
    chk("inv_pulse_end", 32'(drop_pulse_b), 32'h0);
    chk("inv_cnt_hold", 32'(drop_cnt_b), 32'h1);

    // Four more drops back to back: 2, 3, then saturated at 3
    in_valid_b = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k), 32'(drop_cnt_b), (k < 3) ? 32'(k) : 32'h3);
    end
    in_valid_b = 1'b0;
    chk("sat_pulse", 32'(drop_pulse_b), 32'h1);

    // Reset mid-operation with two full slots
    out_ready_b = 3'b000;
    in_sel_b = 2'd0; in_data_b = 8'h01; in_valid_b = 1'b1;
    step();
    in_sel_b = 2'd1; in_data_b = 8'h02;
    step(); in_valid_b = 1'b0; in_sel_b = 2'd0;
    chk("mid_valid", 32'(out_valid_b), 32'h3);
    chk("mid_data", 32'(out_data_b), 32'h000201);
    #1 chk("mid_ready", 32'(in_ready_b), 32'h0);
    rst_b = 1'b1;
    step(); rst_b = 1'b0;
    chk("mrst_valid", 32'(out_valid_b), 32'h0);
    chk("mrst_cnt", 32'(drop_cnt_b), 32'h0);
    chk("mrst_data", 32'(out_data_b), 32'h0);
    chk("mrst_ready", 32'(in_ready_b), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
